// File: rtl/hyper_mvblck_pkg.sv
// Shared types and widths for the LSAB-to-DRAM block mover.
package hyper_mvblck_pkg;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 6;
  localparam int SECT_W = 2;
  localparam int N_SECT = 1 << SECT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Sent-word counter sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hyper_lsab_sect_mux.sv
// Picks the status of the section being drained and fans the error
// acknowledge pulse out to that section only.
module hyper_lsab_sect_mux
  import hyper_mvblck_pkg::*;
(
  input  logic [N_SECT-1:0] empty_vec,
  input  logic [N_SECT-1:0] err_vec,
  input  logic [SECT_W-1:0] sect,
  input  logic              ack_pulse,
  output logic              sect_empty,
  output logic              sect_err,
  output logic [N_SECT-1:0] ack_vec
);

  assign sect_empty = empty_vec[sect];
  assign sect_err   = err_vec[sect];

  generate
    for (genvar gi = 0; gi < N_SECT; gi++) begin : g_ack
      assign ack_vec[gi] = ack_pulse && (sect == SECT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/hyper_mvblck_todram.sv
// Moves COUNT_REQ words from one LSAB section into consecutive DRAM
// addresses, stopping early on an empty section or a device error.
module hyper_mvblck_todram
  import hyper_mvblck_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LSAB_0_EMPTY,
  input  logic              LSAB_1_EMPTY,
  input  logic              LSAB_2_EMPTY,
  input  logic              LSAB_3_EMPTY,
  input  logic              DEV_0_ERR,
  input  logic              DEV_1_ERR,
  input  logic              DEV_2_ERR,
  input  logic              DEV_3_ERR,
  output logic              DEV_0_ERR_ACK,
  output logic              DEV_1_ERR_ACK,
  output logic              DEV_2_ERR_ACK,
  output logic              DEV_3_ERR_ACK,
  output logic              LSAB_READ,
  output logic [SECT_W-1:0] LSAB_SECTION,
  input  logic [ADDR_W-1:0] START_ADDRESS,
  input  logic [CNT_W-1:0]  COUNT_REQ,
  input  logic [SECT_W-1:0] SECTION,
  input  logic [1:0]        DRAM_SEL,
  input  logic              ISSUE,
  output logic [CNT_W-1:0]  COUNT_SENT,
  output logic              WORKING,
  output logic              ABRUPT_STOP,
  output logic              DEVICE_ERROR,
  output logic [ADDR_W-1:0] MCU_COLL_ADDRESS,
  output logic [1:0]        MCU_REQUEST_ACCESS,
  output logic              MCU_WRITE
);

  state_t              state_reg;
  logic [SECT_W-1:0]   sect_reg;
  logic [1:0]          dram_sel_reg;
  logic [CNT_W-1:0]    len_left_reg;
  logic [CNT_W-1:0]    count_sent_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                abrupt_reg;
  logic                dev_err_reg;
  logic                ack_reg;
  logic                mcu_write_reg;

  logic                sect_empty;
  logic                sect_err;
  logic [N_SECT-1:0]   ack_vec;
  logic                lsab_read;

  hyper_lsab_sect_mux u_sect_mux (
    .empty_vec  ({LSAB_3_EMPTY, LSAB_2_EMPTY, LSAB_1_EMPTY, LSAB_0_EMPTY}),
    .err_vec    ({DEV_3_ERR, DEV_2_ERR, DEV_1_ERR, DEV_0_ERR}),
    .sect       (sect_reg),
    .ack_pulse  (ack_reg),
    .sect_empty (sect_empty),
    .sect_err   (sect_err),
    .ack_vec    (ack_vec)
  );

  assign lsab_read = (state_reg == ST_MOVE) && (len_left_reg != '0) &&
                     !sect_empty && !sect_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      sect_reg       <= '0;
      dram_sel_reg   <= '0;
      len_left_reg   <= '0;
      count_sent_reg <= '0;
      addr_reg       <= '0;
      abrupt_reg     <= 1'b0;
      dev_err_reg    <= 1'b0;
      ack_reg        <= 1'b0;
      mcu_write_reg  <= 1'b0;
    end else begin
      // LSAB data arrives one cycle after the pop, so the write trails it.
      mcu_write_reg <= lsab_read;
      ack_reg       <= 1'b0;
      if (mcu_write_reg) begin
        addr_reg       <= addr_reg + ADDR_W'(1);
        count_sent_reg <= sat_inc(count_sent_reg);
      end
      if (lsab_read) begin
        len_left_reg <= len_left_reg - CNT_W'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (ISSUE) begin
            sect_reg       <= SECTION;
            dram_sel_reg   <= DRAM_SEL;
            addr_reg       <= START_ADDRESS;
            len_left_reg   <= COUNT_REQ;
            count_sent_reg <= '0;
            abrupt_reg     <= 1'b0;
            dev_err_reg    <= 1'b0;
            state_reg      <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (len_left_reg == '0) begin
            state_reg <= ST_DRAIN;
          end else if (sect_empty || sect_err) begin
            state_reg   <= ST_DRAIN;
            abrupt_reg  <= 1'b1;
            dev_err_reg <= sect_err;
            ack_reg     <= sect_err;
          end
        end
        ST_DRAIN: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign WORKING            = (state_reg != ST_IDLE);
  assign MCU_REQUEST_ACCESS = WORKING ? dram_sel_reg : 2'b00;
  assign LSAB_READ          = lsab_read;
  assign LSAB_SECTION       = sect_reg;
  assign COUNT_SENT         = count_sent_reg;
  assign ABRUPT_STOP        = abrupt_reg;
  assign DEVICE_ERROR       = dev_err_reg;
  assign MCU_COLL_ADDRESS   = addr_reg;
  assign MCU_WRITE          = mcu_write_reg;
  assign DEV_0_ERR_ACK      = ack_vec[0];
  assign DEV_1_ERR_ACK      = ack_vec[1];
  assign DEV_2_ERR_ACK      = ack_vec[2];
  assign DEV_3_ERR_ACK      = ack_vec[3];

endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Randomized bench for hyper_mvblck_todram against a transfer-level model.
module tb_hyper_mvblck_todram;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] empty_v, err_v;
  logic       DEV_0_ERR_ACK, DEV_1_ERR_ACK, DEV_2_ERR_ACK, DEV_3_ERR_ACK;
  logic       LSAB_READ;
  logic [1:0] LSAB_SECTION;
  logic [8:0] START_ADDRESS;
  logic [5:0] COUNT_REQ;
  logic [1:0] SECTION, DRAM_SEL;
  logic       ISSUE;
  logic [5:0] COUNT_SENT;
  logic       WORKING, ABRUPT_STOP, DEVICE_ERROR;
  logic [8:0] MCU_COLL_ADDRESS;
  logic [1:0] MCU_REQUEST_ACCESS;
  logic       MCU_WRITE;
  logic [3:0] ack_v;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign ack_v = {DEV_3_ERR_ACK, DEV_2_ERR_ACK, DEV_1_ERR_ACK, DEV_0_ERR_ACK};

  hyper_mvblck_todram dut (
    .CLK                (CLK),
    .RST                (RST),
    .LSAB_0_EMPTY       (empty_v[0]),
    .LSAB_1_EMPTY       (empty_v[1]),
    .LSAB_2_EMPTY       (empty_v[2]),
    .LSAB_3_EMPTY       (empty_v[3]),
    .DEV_0_ERR          (err_v[0]),
    .DEV_1_ERR          (err_v[1]),
    .DEV_2_ERR          (err_v[2]),
    .DEV_3_ERR          (err_v[3]),
    .DEV_0_ERR_ACK      (DEV_0_ERR_ACK),
    .DEV_1_ERR_ACK      (DEV_1_ERR_ACK),
    .DEV_2_ERR_ACK      (DEV_2_ERR_ACK),
    .DEV_3_ERR_ACK      (DEV_3_ERR_ACK),
    .LSAB_READ          (LSAB_READ),
    .LSAB_SECTION       (LSAB_SECTION),
    .START_ADDRESS      (START_ADDRESS),
    .COUNT_REQ          (COUNT_REQ),
    .SECTION            (SECTION),
    .DRAM_SEL           (DRAM_SEL),
    .ISSUE              (ISSUE),
    .COUNT_SENT         (COUNT_SENT),
    .WORKING            (WORKING),
    .ABRUPT_STOP        (ABRUPT_STOP),
    .DEVICE_ERROR       (DEVICE_ERROR),
    .MCU_COLL_ADDRESS   (MCU_COLL_ADDRESS),
    .MCU_REQUEST_ACCESS (MCU_REQUEST_ACCESS),
    .MCU_WRITE          (MCU_WRITE)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_working"}, WORKING, 0);
    chk({tag, "_count_sent"}, COUNT_SENT, 0);
    chk({tag, "_abrupt"}, ABRUPT_STOP, 0);
    chk({tag, "_dev_err"}, DEVICE_ERROR, 0);
    chk({tag, "_mcu_write"}, MCU_WRITE, 0);
    chk({tag, "_lsab_read"}, LSAB_READ, 0);
    chk({tag, "_addr"}, MCU_COLL_ADDRESS, 0);
    chk({tag, "_req"}, MCU_REQUEST_ACCESS, 0);
    chk({tag, "_section"}, LSAB_SECTION, 0);
    chk({tag, "_acks"}, ack_v, 0);
  endtask

  // stop_after: reads allowed before the selected section goes empty/errored
  // (64 = never); kind bit0 = EMPTY, bit1 = ERR. rst_after >= 0 resets
  // the block once that many reads have been seen.
  task automatic run_xfer(input logic [8:0] start, input logic [5:0] cnt,
                          input logic [1:0] sect, input logic [1:0] dsel,
                          input int stop_after, input int kind,
                          input bit reissue, input int rst_after);
    int reads = 0, writes = 0, wcyc = 0, cyc = 0;
    int ack_cnt[4] = '{0, 0, 0, 0};
    int exp_reads, exp_abrupt, exp_deverr;
    START_ADDRESS = start; COUNT_REQ = cnt; SECTION = sect; DRAM_SEL = dsel;
    ISSUE = 1'b1;
    empty_v = 4'($urandom); err_v = 4'($urandom);
    @(posedge CLK); #1;
    ISSUE = 1'b0;
    START_ADDRESS = 9'($urandom); COUNT_REQ = 6'($urandom);
    SECTION = 2'($urandom); DRAM_SEL = 2'($urandom);
    while (cyc < 300) begin
      empty_v = 4'($urandom);
      err_v   = 4'($urandom);
      empty_v[sect] = (reads >= stop_after) && kind[0];
      err_v[sect]   = (reads >= stop_after) && kind[1];
      if (reissue && cyc == 1) begin
        ISSUE = 1'b1; START_ADDRESS = 9'($urandom); COUNT_REQ = 6'($urandom);
        SECTION = 2'($urandom);
      end else begin
        ISSUE = 1'b0;
      end
      #1;
      if (!WORKING) break;
      wcyc++;
      chk("req_access", MCU_REQUEST_ACCESS, dsel);
      chk("lsab_section", LSAB_SECTION, sect);
      if (LSAB_READ) reads++;
      if (MCU_WRITE) begin
        chk("write_addr", MCU_COLL_ADDRESS, (int'(start) + writes) % 512);
        writes++;
      end
      for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack_v[i]);
      if (rst_after >= 0 && reads == rst_after) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk_all_zero("mid_reset");
        $display("xfer start=%03h cnt=%0d sect=%0d reset after %0d reads", start, cnt, sect, reads);
        return;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    if (cyc >= 300) chk("timeout", 1, 0);
    ISSUE = 1'b0;
    chk("idle_write", MCU_WRITE, 0);
    chk("idle_read", LSAB_READ, 0);

    exp_reads  = (stop_after < int'(cnt)) ? stop_after : int'(cnt);
    exp_abrupt = (stop_after < int'(cnt)) ? 1 : 0;
    exp_deverr = (exp_abrupt == 1 && kind[1]) ? 1 : 0;
    chk("reads", reads, exp_reads);
    chk("writes", writes, exp_reads);
    chk("count_sent", COUNT_SENT, exp_reads);
    chk("abrupt", ABRUPT_STOP, exp_abrupt);
    chk("dev_err", DEVICE_ERROR, exp_deverr);
    chk("working_cycles", wcyc, exp_reads + 2);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ack%0d", i), ack_cnt[i], (i == int'(sect)) ? exp_deverr : 0);

    repeat (2) begin
      empty_v = 4'($urandom); err_v = 4'($urandom);
      @(posedge CLK); #1;
    end
    chk("hold_count", COUNT_SENT, exp_reads);
    chk("hold_abrupt", ABRUPT_STOP, exp_abrupt);
    chk("hold_dev_err", DEVICE_ERROR, exp_deverr);
    $display("xfer start=%03h cnt=%0d sect=%0d sel=%0d stop=%0d kind=%0d -> sent=%0d abrupt=%0d deverr=%0d",
             start, cnt, sect, dsel, stop_after, kind, COUNT_SENT, ABRUPT_STOP, DEVICE_ERROR);
  endtask

  initial begin
    RST = 1'b1; ISSUE = 1'b0; empty_v = '0; err_v = '0;
    START_ADDRESS = '0; COUNT_REQ = '0; SECTION = '0; DRAM_SEL = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_all_zero("reset");

    run_xfer(9'h1FE, 6'd4, 2'd2, 2'd1, 64, 0, 1'b0, -1);
    run_xfer(9'h055, 6'd0, 2'd0, 2'd2, 64, 0, 1'b0, -1);
    run_xfer(9'h100, 6'd8, 2'd1, 2'd3, 3, 1, 1'b0, -1);
    run_xfer(9'h0F0, 6'd8, 2'd3, 2'd2, 5, 2, 1'b0, -1);
    run_xfer(9'h010, 6'd10, 2'd0, 2'd1, 64, 0, 1'b0, 2);
    run_xfer(9'h123, 6'd6, 2'd1, 2'd3, 64, 0, 1'b0, -1);
    run_xfer(9'h020, 6'd12, 2'd2, 2'd2, 64, 0, 1'b1, -1);
    run_xfer(9'h1F0, 6'd7, 2'd0, 2'd1, 2, 3, 1'b0, -1);
    run_xfer(9'h033, 6'd63, 2'd3, 2'd3, 64, 0, 1'b0, -1);
    run_xfer(9'h044, 6'd5, 2'd1, 2'd1, 0, 2, 1'b0, -1);

    for (int n = 0; n < 25; n++) begin
      int sa, kd;
      sa = ($urandom_range(0, 1) == 0) ? 64 : int'($urandom_range(0, 63));
      kd = int'($urandom_range(1, 3));
      run_xfer(9'($urandom), 6'($urandom), 2'($urandom), 2'($urandom),
               sa, kd, 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
